// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter feeding one FIFO write port, with registered grant/data outputs.
// Optional statistics counters (ack_cnt, stall_cnt) are enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          err_ovf,
  output logic [1:0]                    state
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]                   ack_cnt,
  output logic [7:0]                    stall_cnt
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0]   data_q, data_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic                    err_q;

  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      elig_rot;
  logic                    issue_ok;
  logic                    found;
  logic [PW-1:0]           win;
  logic [FIFO_WIDTH-1:0]   win_data;

  // The requester granted this cycle is masked so it can never win twice in a row.
  assign eligible = req & ~gnt_q;
  // A write already in flight could fill an almost-full FIFO, so it also blocks issue.
  assign issue_ok = !fifo_full && !(fifo_almostfull && wr_en_q);

  always_comb begin
    elig_rot = NUM_REQ'({eligible, eligible} >> ptr_q);
    found    = 1'b0;
    win      = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && elig_rot[k]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PW'(i)) begin
        win_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          state_d = issue_ok ? ACTIVE : STALL;
        end
      end
      ACTIVE: begin
        if (eligible == '0) begin
          state_d = IDLE;
        end else if (!issue_ok) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (eligible == '0) begin
          state_d = IDLE;
        end else if (issue_ok) begin
          state_d = ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = '0;
    wr_en_d = 1'b0;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (state_d == ACTIVE && found) begin
      gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
      wr_en_d = 1'b1;
      data_d  = win_data;
      ptr_d   = PW'((int'(win) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= '0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      err_q   <= err_q | fifo_overflow;
    end
  end

  assign gnt          = gnt_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign err_ovf      = err_q;
  assign state        = state_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] ack_cnt_q;
  logic [7:0]  stall_cnt_q;

  // Ack count wraps freely; stall count saturates so long stalls stay visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ack_cnt_q <= ack_cnt_q + {15'd0, fifo_wr_ack};
      if (state_q == STALL && stall_cnt_q != 8'hFF) begin
        stall_cnt_q <= stall_cnt_q + 8'd1;
      end
    end
  end

  assign ack_cnt   = ack_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic unused_ack;
  assign unused_ack = fifo_wr_ack;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the arbitration rules.
module tb_fifo_wr_arb;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] reqData;
  logic [N-1:0]   gnt;
  logic           fifoWrEn;
  logic [W-1:0]   fifoDataIn;
  logic           fifoFull;
  logic           fifoAlmostFull;
  logic           fifoWrAck;
  logic           fifoOverflow;
  logic           errOvf;
  logic [1:0]     stateOut;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0]    ackCnt;
  logic [7:0]     stallCnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arb #(.NUM_REQ(N), .FIFO_WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (reqData),
    .gnt            (gnt),
    .fifo_wr_en     (fifoWrEn),
    .fifo_data_in   (fifoDataIn),
    .fifo_full      (fifoFull),
    .fifo_almostfull(fifoAlmostFull),
    .fifo_wr_ack    (fifoWrAck),
    .fifo_overflow  (fifoOverflow),
    .err_ovf        (errOvf),
    .state          (stateOut)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .ack_cnt        (ackCnt),
    .stall_cnt      (stallCnt)
`endif
  );

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  logic [N-1:0] mGnt;
  logic         mWrEn;
  logic [W-1:0] mData;
  int           mPtr;
  logic         mErr;
  int           mState;
  int           mAck;
  int           mStall;

  logic [N-1:0] seq036 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mGnt   = '0;
    mWrEn  = 1'b0;
    mData  = '0;
    mPtr   = 0;
    mErr   = 1'b0;
    mState = 0;
    mAck   = 0;
    mStall = 0;
  endtask

  // Behavioural view: the next state depends only on whether anyone is eligible and whether
  // issue is allowed; a grant goes to the first eligible requester at or after the pointer.
  task automatic modelStep();
    logic [N-1:0] elig;
    bit           issueOk;
    int           ns;
    int           w;
    elig    = req & ~mGnt;
    issueOk = !fifoFull && !(fifoAlmostFull && mWrEn);
    if (mState == 2 && mStall < 255) mStall++;
    if (fifoWrAck) mAck = (mAck + 1) % 65536;
    mErr = mErr | fifoOverflow;
    if (elig == '0) ns = 0;
    else if (issueOk) ns = 1;
    else ns = 2;
    if (ns == 1) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && elig[(mPtr + k) % N]) w = (mPtr + k) % N;
      end
      mGnt    = '0;
      mGnt[w] = 1'b1;
      mWrEn   = 1'b1;
      mData   = reqData[w*W +: W];
      mPtr    = (w + 1) % N;
    end else begin
      mGnt  = '0;
      mWrEn = 1'b0;
    end
    mState = ns;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("gnt", gnt, mGnt);
    checkOutput("wrEn", fifoWrEn, mWrEn);
    checkOutput("data", fifoDataIn, mData);
    checkOutput("state", stateOut, mState);
    checkOutput("errOvf", errOvf, mErr);
`ifdef FIFO_WR_ARB_STATS_EN
    checkOutput("ackCnt", ackCnt, mAck);
    checkOutput("stallCnt", stallCnt, mStall);
`endif
  endtask

  initial begin
    rst            = 1'b1;
    req            = '0;
    reqData        = '0;
    fifoFull       = 1'b0;
    fifoAlmostFull = 1'b0;
    fifoWrAck      = 1'b0;
    fifoOverflow   = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstGnt", gnt, 0);
    checkOutput("rstWrEn", fifoWrEn, 0);
    checkOutput("rstData", fifoDataIn, 0);
    checkOutput("rstErr", errOvf, 0);
    checkOutput("rstState", stateOut, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] all requesters held, FIFO never full");
    req = 4'b1111;
    for (int i = 0; i < N; i++) reqData[i*W +: W] = 16'hA000 + 16'(i);
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      checkOutput("rrSeq", gnt, seq036[c]);
      checkOutput("rrWrEn", fifoWrEn, 1);
    end
    applyStimulus();
    applyStimulus();
    checkOutput("gntBeforeRst", gnt, 4'b0100);

    $display("[TB] reset during grant");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abortGnt", gnt, 0);
    checkOutput("abortWrEn", fifoWrEn, 0);
    checkOutput("abortState", stateOut, 0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus();
    checkOutput("firstGntAfterRst", gnt, 4'b0001);

    $display("[TB] single requester held");
    req = 4'b0001;
    reqData[15:0] = 16'h1234;
    for (int c = 0; c < 6; c++) begin
      applyStimulus();
      checkOutput("altGnt", gnt, (c % 2 == 1) ? 4'b0001 : 4'b0000);
      if (c % 2 == 1) checkOutput("altData", fifoDataIn, 16'h1234);
    end

    $display("[TB] almost-full with write in flight, then full");
    req = 4'b1111;
    applyStimulus();
    applyStimulus();
    fifoAlmostFull = 1'b1;
    applyStimulus();
    checkOutput("afWrEn", fifoWrEn, 0);
    checkOutput("afState", stateOut, 2);
    fifoFull = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("fullState", stateOut, 2);
    fifoFull       = 1'b0;
    fifoAlmostFull = 1'b0;
    applyStimulus();
    checkOutput("resumeGnt", gnt, 4'b1000);

    $display("[TB] overflow pulse");
    req = '0;
    applyStimulus();
    checkOutput("errBefore", errOvf, 0);
    fifoOverflow = 1'b1;
    applyStimulus();
    checkOutput("errSet", errOvf, 1);
    fifoOverflow = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("errSticky", errOvf, 1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || mGnt[i]) begin
          req[i] = ($urandom_range(0, 2) == 0);
          reqData[i*W +: W] = 16'($urandom);
        end
      end
      fifoFull       = ($urandom_range(0, 7) == 0);
      fifoAlmostFull = ($urandom_range(0, 3) == 0);
      fifoWrAck      = ($urandom_range(0, 1) == 0);
      fifoOverflow   = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end
    fifoFull       = 1'b0;
    fifoAlmostFull = 1'b0;
    fifoWrAck      = 1'b0;
    fifoOverflow   = 1'b0;

`ifdef FIFO_WR_ARB_STATS_EN
    $display("[TB] statistics counters");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstAckCnt", ackCnt, 0);
    checkOutput("rstStallCnt", stallCnt, 0);
    modelReset();
    @(negedge clk);
    rst      = 1'b0;
    req      = 4'b1111;
    fifoFull = 1'b1;
    for (int c = 0; c < 300; c++) begin
      fifoWrAck = (c % 10 == 0) && (c > 0) && (c <= 50);
      applyStimulus();
    end
    fifoWrAck = 1'b0;
    checkOutput("stallSat", stallCnt, 8'hFF);
    checkOutput("ackFive", ackCnt, 5);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
